vga_text_seq: RTL and testbench

VGA_TEXT_SEQ -- requirements
Module: vga_text_seq

---
 rtl/vga_text_seq.sv | 141 ++++++++++++++
 tb/tb_vga_text_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_seq.sv
// +----------------------------------------------------------------------------+
// | vga_text_seq : 8-slot letter buffer with typewriter reveal and a          |
// |                registered pixel-to-cell lookup for a VGA text box.        |
// | Revision     : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_text_seq #(
  parameter int X0      = 64,
  parameter int Y0      = 200,
  parameter int CW_LOG2 = 6,
  parameter int CH      = 80,
  parameter int TICK    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       wr_valid,
  input  logic [4:0] wr_char,
  output logic       wr_ready,
  input  logic       start,
  input  logic       clear,
  output logic [4:0] letter,
  output logic [5:0] col_x,
  output logic [6:0] row_y,
  output logic       in_text,
  output logic [3:0] count,
  output logic       busy
);

  localparam int              c_TW       = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(TICK - 1);
  localparam logic [10:0]     c_X_LO     = 11'(X0);
  localparam logic [10:0]     c_X_HI     = 11'(X0 + (8 << CW_LOG2));
  localparam logic [10:0]     c_Y_LO     = 11'(Y0);
  localparam logic [10:0]     c_Y_HI     = 11'(Y0 + CH);
  localparam logic [9:0]      c_X0       = 10'(X0);
  localparam logic [9:0]      c_Y0       = 10'(Y0);
  localparam logic [4:0]      c_BLANK    = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TYPE = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_count;
  logic [3:0]      r_reveal;
  logic [c_TW-1:0] r_tick;
  logic [4:0]      r_slot [8];

  logic [4:0]      r_letter;
  logic [5:0]      r_col_x;
  logic [6:0]      r_row_y;
  logic            r_in_text;

  logic            w_wr;
  logic            w_in_text;
  logic [9:0]      w_hoff;
  logic [6:0]      w_row;
  logic [3:0]      w_sidx;
  logic [4:0]      w_letter;

  assign wr_ready = (r_state == S_IDLE) && (r_count < 4'd8);
  assign w_wr     = wr_valid && wr_ready;
  assign busy     = (r_state == S_TYPE);
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= 4'd0;
      r_reveal <= 4'd0;
      r_tick   <= '0;
      for (int i = 0; i < 8; i++) r_slot[i] <= c_BLANK;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_count  <= 4'd0;
      r_reveal <= 4'd0;
      r_tick   <= '0;
      for (int i = 0; i < 8; i++) r_slot[i] <= c_BLANK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            r_slot[r_count[2:0]] <= wr_char;
            r_count              <= r_count + 4'd1;
          end
          // A write landing in the same cycle as start makes an empty buffer non-empty.
          if (start && ((r_count != 4'd0) || w_wr)) begin
            r_state  <= S_TYPE;
            r_tick   <= '0;
            r_reveal <= 4'd0;
          end
        end
        S_TYPE: begin
          if (r_tick == c_TICK_MAX) begin
            r_tick   <= '0;
            r_reveal <= r_reveal + 4'd1;
            if ((r_reveal + 4'd1) == r_count) r_state <= S_SHOW;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_SHOW:  r_state <= S_SHOW;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_text = ({1'b0, h_cnt} >= c_X_LO) && ({1'b0, h_cnt} < c_X_HI) &&
                     ({1'b0, v_cnt} >= c_Y_LO) && ({1'b0, v_cnt} < c_Y_HI);
  assign w_hoff    = w_in_text ? (h_cnt - c_X0) : 10'd0;
  assign w_row     = w_in_text ? 7'(v_cnt - c_Y0) : 7'd0;
  assign w_sidx    = 4'(w_hoff >> CW_LOG2);
  assign w_letter  = (w_in_text && (w_sidx < r_reveal)) ? r_slot[w_sidx[2:0]] : c_BLANK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_letter  <= c_BLANK;
      r_col_x   <= 6'd0;
      r_row_y   <= 7'd0;
      r_in_text <= 1'b0;
    end else begin
      r_letter  <= w_letter;
      r_col_x   <= w_hoff[5:0];
      r_row_y   <= w_row;
      r_in_text <= w_in_text;
    end
  end

  assign letter  = r_letter;
  assign col_x   = r_col_x;
  assign row_y   = r_row_y;
  assign in_text = r_in_text;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_seq.sv
// +----------------------------------------------------------------------------+
// | tb_vga_text_seq : scoreboard bench for vga_text_seq with TICK=4.          |
// | Revision        : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_text_seq;

  localparam int X0 = 64;
  localparam int Y0 = 200;

  localparam int F_LETTER = 0;
  localparam int F_COLX   = 1;
  localparam int F_ROWY   = 2;
  localparam int F_INTEXT = 3;
  localparam int F_BUSY   = 4;
  localparam int F_COUNT  = 5;
  localparam int F_READY  = 6;

  logic       clk;
  logic       rst_n;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       wr_valid;
  logic [4:0] wr_char;
  logic       wr_ready;
  logic       start;
  logic       clear;
  logic [4:0] letter;
  logic [5:0] col_x;
  logic [6:0] row_y;
  logic       in_text;
  logic [3:0] count;
  logic       busy;

  vga_text_seq #(
    .X0(X0), .Y0(Y0), .CW_LOG2(6), .CH(80), .TICK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .start(start), .clear(clear), .letter(letter), .col_x(col_x),
    .row_y(row_y), .in_text(in_text), .count(count), .busy(busy)
  );

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_field(input int f);
    case (f)
      F_LETTER: return int'(letter);
      F_COLX:   return int'(col_x);
      F_ROWY:   return int'(row_y);
      F_INTEXT: return int'(in_text);
      F_BUSY:   return int'(busy);
      F_COUNT:  return int'(count);
      default:  return int'(wr_ready);
    endcase
  endfunction

  task automatic expect_at(input string nm, input int f, input int v, input int c);
    q.push_back('{cyc: c, fld: f, val: v, name: nm});
  endtask

  // Monitor: compares every queued expectation due in the current cycle.
  always @(negedge clk) begin
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if ((q[i].cyc < cyc) || (get_field(q[i].fld) != q[i].val)) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%0d expected=%0d", q[i].name, q[i].cyc,
                   get_field(q[i].fld), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int exp_ready);
    wr_valid = 1'b1;
    wr_char  = 5'(ch);
    expect_at("wr_ready", F_READY, exp_ready, cyc);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pix(input int h, input int v, input int l, input int cx, input int ry,
                     input int it);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    expect_at("pix_letter", F_LETTER, l, cyc + 1);
    expect_at("pix_col_x", F_COLX, cx, cyc + 1);
    expect_at("pix_row_y", F_ROWY, ry, cyc + 1);
    expect_at("pix_in_text", F_INTEXT, it, cyc + 1);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    expect_at("clear_count", F_COUNT, 0, cyc + 1);
    expect_at("clear_busy", F_BUSY, 0, cyc + 1);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int chars [4];
    chars = '{19, 4, 18, 19};

    rst_n = 1'b0; wr_valid = 1'b0; wr_char = 5'd0; start = 1'b0; clear = 1'b0;
    h_cnt = 10'(X0 + 5); v_cnt = 10'(Y0 + 5);
    repeat (2) @(negedge clk);
    expect_at("rst_letter", F_LETTER, 31, cyc);
    expect_at("rst_in_text", F_INTEXT, 0, cyc);
    expect_at("rst_col_x", F_COLX, 0, cyc);
    expect_at("rst_row_y", F_ROWY, 0, cyc);
    expect_at("rst_busy", F_BUSY, 0, cyc);
    expect_at("rst_count", F_COUNT, 0, cyc);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // "TEST" typewriter reveal
    for (int k = 0; k < 4; k++) wr(chars[k], 1);
    s = cyc;
    start = 1'b1;
    expect_at("pre_start_busy", F_BUSY, 0, s);
    expect_at("test_count", F_COUNT, 4, s);
    expect_at("type_busy", F_BUSY, 1, s + 1);
    expect_at("type_busy_last", F_BUSY, 1, s + 16);
    expect_at("show_busy", F_BUSY, 0, s + 17);
    expect_at("show_count", F_COUNT, 4, s + 17);
    at_cyc(s + 1);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_cyc(s + 2 + 4 * k);
      h_cnt = 10'(X0 + 64 * k + 5);
      v_cnt = 10'(Y0 + 3);
      expect_at("reveal_before", F_LETTER, 31, s + 5 + 4 * k);
      expect_at("reveal_after", F_LETTER, chars[k], s + 6 + 4 * k);
    end
    at_cyc(s + 18);

    // Pixel lookup in SHOW, including box edges
    pix(X0 + 64, Y0 + 10, 4, 0, 10, 1);
    pix(X0 + 256, Y0 + 10, 31, 0, 10, 1);
    pix(X0 - 1, Y0 + 10, 31, 0, 0, 0);
    pix(X0 + 511, Y0 + 79, 31, 63, 79, 1);
    pix(X0 + 512, Y0 + 10, 31, 0, 0, 0);
    pix(X0 + 64, Y0 + 80, 31, 0, 0, 0);
    pix(X0 + 255, Y0, 19, 63, 0, 1);
    pix(X0, Y0 - 1, 31, 0, 0, 0);
    start = 1'b1;
    expect_at("show_start_busy", F_BUSY, 0, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wr(7, 0);
    expect_at("show_wr_dropped", F_COUNT, 4, cyc);

    // Overfill: 9 writes, only 8 stored
    pulse_clear();
    for (int i = 0; i < 9; i++) wr(i, (i < 8) ? 1 : 0);
    expect_at("full_count", F_COUNT, 8, cyc);
    expect_at("full_ready", F_READY, 0, cyc);
    s = cyc;
    start = 1'b1;
    expect_at("full_busy_last", F_BUSY, 1, s + 32);
    expect_at("full_show", F_BUSY, 0, s + 33);
    @(negedge clk);
    start = 1'b0;
    at_cyc(s + 34);
    pix(X0 + 1, Y0, 0, 1, 0, 1);
    pix(X0 + 7 * 64 + 1, Y0 + 1, 7, 1, 1, 1);

    // start with an empty buffer
    pulse_clear();
    start = 1'b1;
    expect_at("empty_start_busy", F_BUSY, 0, cyc + 1);
    expect_at("empty_start_ready", F_READY, 1, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    expect_at("empty_start_busy2", F_BUSY, 0, cyc + 1);
    @(negedge clk);

    // start together with the first write
    h_cnt = 10'(X0 + 5); v_cnt = 10'(Y0 + 5);
    s = cyc;
    wr_valid = 1'b1; wr_char = 5'd1; start = 1'b1;
    expect_at("wrstart_busy", F_BUSY, 1, s + 1);
    expect_at("wrstart_count", F_COUNT, 1, s + 1);
    expect_at("wrstart_busy_last", F_BUSY, 1, s + 4);
    expect_at("wrstart_show", F_BUSY, 0, s + 5);
    expect_at("wrstart_letter", F_LETTER, 1, s + 6);
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0;
    at_cyc(s + 7);

    // start while busy leaves reveal timing untouched
    pulse_clear();
    wr(2, 1); wr(3, 1); wr(4, 1);
    s = cyc;
    start = 1'b1;
    expect_at("rebusy_letter_before", F_LETTER, 31, s + 5);
    expect_at("rebusy_letter_after", F_LETTER, 2, s + 6);
    expect_at("rebusy_busy_last", F_BUSY, 1, s + 12);
    expect_at("rebusy_show", F_BUSY, 0, s + 13);
    @(negedge clk);
    start = 1'b0;
    at_cyc(s + 3);
    start = 1'b1;
    at_cyc(s + 4);
    start = 1'b0;
    at_cyc(s + 14);

    // clear with a simultaneous write during TYPE
    pulse_clear();
    wr(5, 1); wr(6, 1);
    s = cyc;
    start = 1'b1;
    expect_at("clrtype_letter", F_LETTER, 5, s + 6);
    expect_at("clrtype_busy_pre", F_BUSY, 1, s + 7);
    @(negedge clk);
    start = 1'b0;
    at_cyc(s + 7);
    clear = 1'b1; wr_valid = 1'b1; wr_char = 5'd9;
    expect_at("clrtype_busy", F_BUSY, 0, s + 8);
    expect_at("clrtype_count", F_COUNT, 0, s + 8);
    expect_at("clrtype_ready", F_READY, 1, s + 8);
    expect_at("clrtype_letter_blank", F_LETTER, 31, s + 9);
    expect_at("clrtype_idle", F_BUSY, 0, s + 12);
    at_cyc(s + 8);
    clear = 1'b0; wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) pix(X0 + 64 * k + 2, Y0 + 2, 31, 2, 2, 1);

    // asynchronous reset mid-TYPE at reveal=2
    wr(10, 1); wr(11, 1); wr(12, 1); wr(13, 1);
    h_cnt = 10'(X0 + 5); v_cnt = 10'(Y0 + 5);
    s = cyc;
    start = 1'b1;
    expect_at("prerst_letter", F_LETTER, 10, s + 9);
    expect_at("prerst_busy", F_BUSY, 1, s + 9);
    @(negedge clk);
    start = 1'b0;
    at_cyc(s + 9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_at("arst_letter", F_LETTER, 31, cyc);
    expect_at("arst_in_text", F_INTEXT, 0, cyc);
    expect_at("arst_col_x", F_COLX, 0, cyc);
    expect_at("arst_row_y", F_ROWY, 0, cyc);
    expect_at("arst_busy", F_BUSY, 0, cyc);
    expect_at("arst_count", F_COUNT, 0, cyc);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_at("postrst_ready", F_READY, 1, cyc);
    start = 1'b1;
    expect_at("postrst_busy", F_BUSY, 0, cyc + 1);
    expect_at("postrst_letter", F_LETTER, 31, cyc + 1);
    @(negedge clk);
    start = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      $display("FAIL scoreboard_leftover actual=%0d expected=0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
